// File: rtl/seq_pkg.sv
// Shared types and constants for the burst scheduler and its bench model of the
// sequence generator.
package seq_pkg;

  localparam int SEQ_LEN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN1,
    ST_DRAIN2
  } seq_sched_state_t;

  // Generator output order starting from its reset position.
  localparam logic [7:0] SEQ_TABLE [8] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

endpackage

// File: rtl/seq_rr_arbiter.sv
// One-hot requester pick. Round-robin from ptr+1 by default; lowest index wins
// when SEQ_SCHED_FIXED_PRIO_EN is defined (no pointer port in that build).
module seq_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef SEQ_SCHED_FIXED_PRIO_EN
  input  logic [IDW-1:0]  ptr,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin : pick
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    gnt   = '0;
    idx   = '0;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      j = i;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
`else
    // Search wraps so the last winner is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
`endif
  end

endmodule

// File: rtl/seq_burst_sched.sv
// Burst scheduler sharing one sequence generator among NREQ requesters.
// Define SEQ_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module seq_burst_sched
  import seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*3-1:0]     req_len,
  output logic [NREQ-1:0]       gnt,
  output logic                  gen_en,
  input  logic [7:0]            gen_data,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic [NREQ-1:0]       done
);

  seq_sched_state_t state, state_nxt;
  logic [SEQ_LEN_W-1:0] cnt, cnt_nxt;
  logic [NREQ-1:0][SEQ_LEN_W-1:0] len_a;
  logic [NREQ-1:0] win_gnt;
  logic [IDW-1:0]  win_idx;
  logic            grant;
  logic            en_q;

  assign len_a = req_len;

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  seq_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req),
    .gnt (win_gnt),
    .idx (win_idx)
  );
`else
  logic [IDW-1:0] ptr;

  seq_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // Reset to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst)        ptr <= IDW'(NREQ - 1);
    else if (grant) ptr <= win_idx;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          cnt_nxt   = len_a[win_idx];
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (cnt == '0) state_nxt = ST_DRAIN1;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_DRAIN1: state_nxt = ST_DRAIN2;
      ST_DRAIN2: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gnt       <= '0;
      out_id    <= '0;
      en_q      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        gnt    <= win_gnt;
        out_id <= win_idx;
      end else if (state == ST_DRAIN2) begin
        gnt <= '0;
      end
      // Generator data lags its enable by one cycle; capture one cycle later.
      en_q      <= gen_en;
      out_valid <= en_q;
      if (en_q) out_data <= gen_data;
    end
  end

  assign gen_en = (state == ST_BURST);
  // Last byte of the burst lands in DRAIN2, two cycles after the last enable.
  assign done   = (state == ST_DRAIN2) ? gnt : '0;

endmodule

// File: tb/tb_seq_burst_sched.sv
// Directed bench for seq_burst_sched with a behavioural sequence generator model.
module tb_seq_burst_sched;
  import seq_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_len;
  logic [3:0]  gnt;
  logic        gen_en;
  logic [7:0]  gen_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [3:0]  done;
  logic [2:0]  gpos;

  int checks = 0;
  int errors = 0;

  seq_burst_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .gnt       (gnt),
    .gen_en    (gen_en),
    .gen_data  (gen_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_id    (out_id),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Generator: registered data, position advances on each enable.
  always @(posedge clk) begin
    if (rst) begin
      gpos     <= 3'd0;
      gen_data <= 8'h00;
    end else if (gen_en) begin
      gen_data <= SEQ_TABLE[gpos];
      gpos     <= gpos + 3'd1;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [11:0] len;
    logic [19:0] exp;  // {gnt, gen_en, out_valid, out_data, out_id, done}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [11:0] l, input logic [3:0] g,
                     input logic e, input logic v, input logic [7:0] d,
                     input logic [1:0] id, input logic [3:0] dn);
    vec_t x;
    x.req = r; x.len = l; x.exp = {g, e, v, d, id, dn};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {gnt, gen_en, out_valid, out_data, out_id, done};
  endfunction

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [7:0] got_b [16];
  int         got_n;
  logic [3:0] got_done;
  logic [1:0] got_id;

  // Gather returned bytes until a done pulse or the cycle budget runs out.
  task automatic collect(input int budget);
    got_n = 0; got_done = '0; got_id = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got_n < 16) got_b[got_n] = out_data;
        got_n++;
      end
      if (done != '0) begin
        got_done = done;
        got_id   = out_id;
        return;
      end
    end
  endtask

  initial begin
    int id_e;
    int bad;
    rst = 1'b1; req = 4'b1111; req_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(outs()), 32'd0);
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // len 2 on req0, then len 7 on req1 (stream wraps).
    add(4'h1, 12'h002, 4'h0, 0, 0, 8'h00, 2'd0, 4'h0);
    add(4'h1, 12'h002, 4'h1, 1, 0, 8'h00, 2'd0, 4'h0);
    add(4'h1, 12'h002, 4'h1, 1, 0, 8'h00, 2'd0, 4'h0);
    add(4'h1, 12'h002, 4'h1, 1, 1, 8'hAF, 2'd0, 4'h0);
    add(4'h1, 12'h002, 4'h1, 0, 1, 8'hBC, 2'd0, 4'h0);
    add(4'h1, 12'h002, 4'h1, 0, 1, 8'hE2, 2'd0, 4'h1);
    add(4'h2, 12'h038, 4'h0, 0, 0, 8'hE2, 2'd0, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 0, 8'hE2, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 0, 8'hE2, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 1, 8'h78, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 1, 8'hFF, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 1, 8'hE2, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 1, 8'h0B, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 1, 8'h8D, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 1, 1, 8'hAF, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 0, 1, 8'hBC, 2'd1, 4'h0);
    add(4'h2, 12'h038, 4'h2, 0, 1, 8'hE2, 2'd1, 4'h2);
    add(4'h0, 12'h038, 4'h0, 0, 0, 8'hE2, 2'd1, 4'h0);

    for (int k = 0; k < vecs.size(); k++) begin
      req = vecs[k].req; req_len = vecs[k].len;
      @(negedge clk);
      chk($sformatf("vec%0d", k), 32'(outs()), 32'(vecs[k].exp));
      @(posedge clk); #1;
    end

    // All requesters held, len 0: one byte per grant.
    do_rst();
    req = 4'b1111; req_len = '0;
    for (int k = 0; k < 5; k++) begin
`ifdef SEQ_SCHED_FIXED_PRIO_EN
      id_e = 0;
`else
      id_e = k % 4;
`endif
      collect(20);
      chk($sformatf("rr_done%0d", k), 32'(got_done), 32'(4'b0001 << id_e));
      chk($sformatf("rr_id%0d", k), 32'(got_id), 32'(id_e));
      chk($sformatf("rr_n%0d", k), 32'(got_n), 32'd1);
      chk($sformatf("rr_byte%0d", k), 32'(got_b[0]), 32'(SEQ_TABLE[k]));
    end
    req = '0;

    // req dropped after the grant: burst still completes.
    do_rst();
    req = 4'b0100; req_len = 12'h0C0;
    @(posedge clk); #1;
    req = '0;
    collect(30);
    chk("drop_n", 32'(got_n), 32'd4);
    chk("drop_done", 32'(got_done), 32'h4);
    chk("drop_id", 32'(got_id), 32'd2);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drop_byte%0d", k), 32'(got_b[k]), 32'(SEQ_TABLE[k]));

    // req_len change after grant is ignored.
    do_rst();
    req = 4'b0001; req_len = 12'h001;
    @(posedge clk); #1;
    req_len = 12'h006;
    collect(30);
    req = '0;
    chk("len_n", 32'(got_n), 32'd2);
    chk("len_done", 32'(got_done), 32'h1);
    chk("len_b0", 32'(got_b[0]), 32'hAF);
    chk("len_b1", 32'(got_b[1]), 32'hBC);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || done != '0) bad++;
    end
    chk("len_quiet", 32'(bad), 32'd0);

    // rst in the second BURST cycle of a 5-byte burst.
    do_rst();
    req = 4'b0001; req_len = 12'h004;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pre_en", 32'(gen_en), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_outputs", 32'(outs()), 32'd0);
    rst = 1'b0; req = '0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || done != '0 || gnt != '0) bad++;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
